image_pixel_stream_proc: RTL and testbench

- Synthesisable, parametrised successor to the file-driven image reader.
- Accepts a raster frame as a valid/ready pixel stream, PPC pixels per beat.
- Applies a run-time selectable point operation: bypass, saturating brighten, saturating darken, or threshold.
- Emits the processed stream with frame/line markers and a one-cycle ctrl_done at frame end. Sits between the frame source (DMA/sensor) and the display/writer block.

---
 rtl/image_pixel_stream_proc.sv | 224 ++++++++++++++++++++++
 tb/tb_image_pixel_stream_proc.sv | 184 ++++++++++++++++++
 2 files changed

// File: rtl/image_pixel_stream_proc.sv
// rtl/image_pixel_stream_proc.sv - pixel stream point-operation processor with frame/line markers
// Optional IMG_FRAME_STATS_EN adds stat_count (bright-pixel count per frame).
module image_pixel_stream_proc #(
  parameter int WIDTH          = 640,
  parameter int HEIGHT         = 480,
  parameter int PPC            = 2,
  parameter int DW             = 8,
  parameter int START_UP_DELAY = 10,
  parameter int H_BLANK        = 4
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  start,
  input  logic [1:0]            cfg_mode,
  input  logic [DW-1:0]         cfg_value,
  input  logic [DW-1:0]         cfg_threshold,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [PPC*3*DW-1:0]   s_data,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [PPC*3*DW-1:0]   m_data,
  output logic                  m_sof,
  output logic                  m_eol,
  output logic                  busy,
  output logic                  ctrl_done
`ifdef IMG_FRAME_STATS_EN
  ,
  output logic [$clog2(WIDTH*HEIGHT+1)-1:0] stat_count
`endif
);

  localparam int COLS    = WIDTH / PPC;
  localparam int COLW    = (COLS > 1) ? $clog2(COLS) : 1;
  localparam int ROWW    = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int DLY_MAX = (START_UP_DELAY > H_BLANK) ? START_UP_DELAY : H_BLANK;
  localparam int DLYW    = $clog2(DLY_MAX + 2);
  localparam int PW      = 3 * DW;
  localparam int BW      = PPC * PW;

  localparam logic [DLYW-1:0] SU_LIM = DLYW'(START_UP_DELAY);
  localparam logic [DLYW-1:0] HB_LIM = DLYW'(H_BLANK);
  localparam logic [COLW-1:0] COL_LAST = COLW'(COLS - 1);
  localparam logic [ROWW-1:0] ROW_LAST = ROWW'(HEIGHT - 1);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_STARTUP = 3'd1;
  localparam logic [2:0] S_ACTIVE  = 3'd2;
  localparam logic [2:0] S_LBLANK  = 3'd3;
  localparam logic [2:0] S_FLUSH   = 3'd4;
  localparam logic [2:0] S_DONE    = 3'd5;

  logic [2:0]      state_q, state_d;
  logic [DLYW-1:0] dly_q, dly_d, dly_inc;
  logic [COLW-1:0] col_q, col_d;
  logic [ROWW-1:0] row_q, row_d;
  logic [1:0]      mode_q, mode_d;
  logic [DW-1:0]   value_q, value_d, thr_q, thr_d;
  logic            m_valid_q, m_valid_d, m_sof_q, m_sof_d, m_eol_q, m_eol_d;
  logic [BW-1:0]   m_data_q, m_data_d, proc_data;
  logic            s_ready_c, accept, last_col, last_row;

  logic [PPC-1:0]  bright;
  logic [DW-1:0]   comp, res;
  logic [DW:0]     add;
  logic [DW+1:0]   sum, thr3;

  // Point operation on every component of every pixel, using the frame-latched config.
  always_comb begin
    proc_data = '0;
    bright    = '0;
    comp      = '0;
    res       = '0;
    add       = '0;
    sum       = '0;
    thr3      = ({2'b00, thr_q} << 1) + {2'b00, thr_q};
    for (int k = 0; k < PPC; k++) begin
      sum = {2'b00, s_data[k*PW +: DW]} + {2'b00, s_data[k*PW+DW +: DW]}
          + {2'b00, s_data[k*PW+2*DW +: DW]};
      bright[k] = (sum > thr3);
      for (int c = 0; c < 3; c++) begin
        comp = s_data[k*PW + c*DW +: DW];
        add  = {1'b0, comp} + {1'b0, value_q};
        case (mode_q)
          2'd1:    res = add[DW] ? '1 : add[DW-1:0];
          2'd2:    res = (comp >= value_q) ? (comp - value_q) : '0;
          2'd3:    res = bright[k] ? '1 : '0;
          default: res = comp;
        endcase
        proc_data[k*PW + c*DW +: DW] = res;
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    col_d     = col_q;
    row_d     = row_q;
    mode_d    = mode_q;
    value_d   = value_q;
    thr_d     = thr_q;
    m_valid_d = m_valid_q;
    m_data_d  = m_data_q;
    m_sof_d   = m_sof_q;
    m_eol_d   = m_eol_q;
    s_ready_c = (state_q == S_ACTIVE) && (!m_valid_q || m_ready);
    accept    = s_ready_c && s_valid;
    last_col  = (col_q == COL_LAST);
    last_row  = (row_q == ROW_LAST);
    dly_inc   = dly_q + 1'b1;

    if (m_valid_q && m_ready) m_valid_d = 1'b0;
    if (accept) begin
      m_valid_d = 1'b1;
      m_data_d  = proc_data;
      m_sof_d   = (col_q == '0) && (row_q == '0);
      m_eol_d   = last_col;
    end

    case (state_q)
      S_IDLE: if (start) begin
        state_d = S_STARTUP;
        dly_d   = '0;
        col_d   = '0;
        row_d   = '0;
        mode_d  = cfg_mode;
        value_d = cfg_value;
        thr_d   = cfg_threshold;
      end
      S_STARTUP: begin
        dly_d = dly_inc;
        if (dly_inc >= SU_LIM) state_d = S_ACTIVE;
      end
      S_ACTIVE: if (accept) begin
        if (last_col) begin
          col_d = '0;
          dly_d = '0;
          if (last_row) begin
            row_d   = '0;
            state_d = S_FLUSH;
          end else begin
            row_d   = row_q + 1'b1;
            state_d = S_LBLANK;
          end
        end else begin
          col_d = col_q + 1'b1;
        end
      end
      S_LBLANK: begin
        dly_d = dly_inc;
        if (dly_inc >= HB_LIM) state_d = S_ACTIVE;
      end
      S_FLUSH: if (!m_valid_q || m_ready) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      state_q   <= S_IDLE;
      dly_q     <= '0;
      col_q     <= '0;
      row_q     <= '0;
      mode_q    <= '0;
      value_q   <= '0;
      thr_q     <= '0;
      m_valid_q <= 1'b0;
      m_data_q  <= '0;
      m_sof_q   <= 1'b0;
      m_eol_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      col_q     <= col_d;
      row_q     <= row_d;
      mode_q    <= mode_d;
      value_q   <= value_d;
      thr_q     <= thr_d;
      m_valid_q <= m_valid_d;
      m_data_q  <= m_data_d;
      m_sof_q   <= m_sof_d;
      m_eol_q   <= m_eol_d;
    end
  end

`ifdef IMG_FRAME_STATS_EN
  localparam int STW = $clog2(WIDTH*HEIGHT+1);
  logic [STW-1:0] cnt_q, cnt_d, stat_q, stat_d, beat_cnt;

  // Running count is published only on the FLUSH->DONE edge so it is valid during DONE.
  always_comb begin
    beat_cnt = '0;
    for (int k = 0; k < PPC; k++) beat_cnt = beat_cnt + STW'(bright[k]);
    cnt_d  = cnt_q;
    stat_d = stat_q;
    if (state_q == S_IDLE && start) cnt_d = '0;
    else if (accept)                cnt_d = cnt_q + beat_cnt;
    if (state_q == S_FLUSH && state_d == S_DONE) stat_d = cnt_q;
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      cnt_q  <= '0;
      stat_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      stat_q <= stat_d;
    end
  end

  assign stat_count = stat_q;
`endif

  assign s_ready   = s_ready_c;
  assign m_valid   = m_valid_q;
  assign m_data    = m_data_q;
  assign m_sof     = m_sof_q;
  assign m_eol     = m_eol_q;
  assign busy      = (state_q != S_IDLE);
  assign ctrl_done = (state_q == S_DONE);

endmodule

// File: tb/tb_image_pixel_stream_proc.sv
// tb/tb_image_pixel_stream_proc.sv - directed self-checking bench for image_pixel_stream_proc
module tb_image_pixel_stream_proc;

  logic        HCLK = 1'b0;
  logic        HRESET = 1'b1;
  logic        start = 1'b0;
  logic [1:0]  cfg_mode = '0;
  logic [7:0]  cfg_value = '0;
  logic [7:0]  cfg_threshold = '0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [47:0] s_data = '0;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [47:0] m_data;
  logic        m_sof, m_eol, busy, ctrl_done;
`ifdef IMG_FRAME_STATS_EN
  logic [3:0]  stat_count;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [47:0] in_beats [4];
  logic [47:0] exp_beats [4];

  image_pixel_stream_proc #(
    .WIDTH(4), .HEIGHT(2), .PPC(2), .DW(8), .START_UP_DELAY(3), .H_BLANK(2)
  ) dut (
    .HCLK(HCLK), .HRESET(HRESET), .start(start),
    .cfg_mode(cfg_mode), .cfg_value(cfg_value), .cfg_threshold(cfg_threshold),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol), .busy(busy), .ctrl_done(ctrl_done)
`ifdef IMG_FRAME_STATS_EN
    , .stat_count(stat_count)
`endif
  );

  always #5 HCLK = ~HCLK;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Entered at posedge+1; runs one frame for a fixed cycle budget.
  task automatic run_frame(input logic [1:0] mode, input logic [7:0] val, input logic [7:0] thr,
                           input int rdy_div, input int chg_cyc, input bit chk_timing,
                           input int exp_stat);
    int in_idx = 0;
    int out_idx = 0;
    int done_cnt = 0;
    int acc_cyc [4] = '{0, 0, 0, 0};
    cfg_mode = mode;
    cfg_value = val;
    cfg_threshold = thr;
    s_valid = 1'b0;
    start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    for (int cyc = 1; cyc < 80; cyc++) begin
      m_ready = (cyc % rdy_div == 0);
      if (cyc == chg_cyc) begin
        cfg_mode = 2'd0;
        start = 1'b1;
      end else begin
        start = 1'b0;
      end
      s_valid = (in_idx < 4);
      s_data = in_beats[(in_idx < 4) ? in_idx : 0];
      #1;
      if (m_valid) chk("m_data", m_data, exp_beats[(out_idx < 4) ? out_idx : 3]);
      if (ctrl_done) begin
        done_cnt++;
        chk("done_after_drain", out_idx, 4);
        if (chk_timing) chk("done_cycle", cyc, 11);
`ifdef IMG_FRAME_STATS_EN
        if (exp_stat >= 0) chk("stat_count", stat_count, exp_stat);
`endif
      end
      if (s_valid && s_ready) begin
        acc_cyc[in_idx] = cyc;
        in_idx++;
      end
      if (m_valid && m_ready) begin
        if (out_idx >= 4) chk("extra_beat", out_idx, 3);
        else begin
          chk("m_sof", m_sof, out_idx == 0);
          chk("m_eol", m_eol, out_idx % 2 == 1);
        end
        out_idx++;
      end
      @(posedge HCLK); #1;
    end
    start = 1'b0;
    s_valid = 1'b0;
    chk("beats_in", in_idx, 4);
    chk("beats_out", out_idx, 4);
    chk("done_pulses", done_cnt, 1);
    chk("idle_after", busy, 0);
    if (chk_timing) begin
      chk("startup_gap", acc_cyc[0], 4);
      chk("hblank_gap", acc_cyc[2] - acc_cyc[1], 3);
    end
  endtask

  initial begin
    int dn;
    #12;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_s_ready", s_ready, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", ctrl_done, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_markers", {m_sof, m_eol}, 0);
`ifdef IMG_FRAME_STATS_EN
    chk("rst_stat", stat_count, 0);
`endif
    HRESET = 1'b0;
    @(posedge HCLK); #1;

    // Bypass with timing checks
    in_beats  = '{48'h112233_445566, 48'hAABBCC_DDEEFF, 48'h010203_040506, 48'hFEDCBA_987654};
    exp_beats = in_beats;
    run_frame(2'd0, 8'h40, 8'd100, 1, 0, 1'b1, -1);

    // Brighten 0x40
    in_beats  = '{48'hBFC001_0010F0, 48'h000000_FFFFFF, 48'h123456_7F8081, 48'h3F3F3F_C0C0C0};
    exp_beats = '{48'hFFFF41_4050FF, 48'h404040_FFFFFF, 48'h527496_BFC0C1, 48'h7F7F7F_FFFFFF};
    run_frame(2'd1, 8'h40, 8'd0, 1, 0, 1'b0, -1);

    // Darken 0x40 under backpressure
    in_beats  = '{48'h40413F_305580, 48'hFFFFFF_000000, 48'h123456_7F8081, 48'hC0C0C0_010203};
    exp_beats = '{48'h000100_001540, 48'hBFBFBF_000000, 48'h000016_3F4041, 48'h808080_000000};
    run_frame(2'd2, 8'h40, 8'd0, 3, 0, 1'b0, -1);

    // Threshold 100, 3 of 8 pixels bright
    in_beats  = '{48'h646464_656464, 48'h000000_FFFFFF, 48'h656463_0000FF, 48'h019696_808000};
    exp_beats = '{48'h000000_FFFFFF, 48'h000000_FFFFFF, 48'h000000_000000, 48'hFFFFFF_000000};
    run_frame(2'd3, 8'h00, 8'd100, 1, 0, 1'b0, 3);

    // Mode change and start re-pulse during line blanking
    in_beats  = '{48'hBFC001_0010F0, 48'h000000_FFFFFF, 48'h123456_7F8081, 48'h3F3F3F_C0C0C0};
    exp_beats = '{48'hFFFF41_4050FF, 48'h404040_FFFFFF, 48'h527496_BFC0C1, 48'h7F7F7F_FFFFFF};
    run_frame(2'd1, 8'h40, 8'd0, 1, 6, 1'b0, -1);

    // Reset mid-line
    cfg_mode = 2'd0;
    m_ready = 1'b1;
    start = 1'b1;
    @(posedge HCLK); #1;
    start = 1'b0;
    s_valid = 1'b1;
    s_data = 48'h112233_445566;
    repeat (4) begin
      @(posedge HCLK); #1;
    end
    chk("pre_rst_valid", m_valid, 1);
    HRESET = 1'b1;
    s_valid = 1'b0;
    @(posedge HCLK); #1;
    chk("mid_rst_m_valid", m_valid, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_s_ready", s_ready, 0);
    chk("mid_rst_data", {m_data, m_sof, m_eol, ctrl_done}, 0);
    HRESET = 1'b0;
    dn = 0;
    repeat (20) begin
      @(posedge HCLK); #1;
      if (ctrl_done) dn++;
    end
    chk("no_done_after_rst", dn, 0);
    in_beats  = '{48'h112233_445566, 48'hAABBCC_DDEEFF, 48'h010203_040506, 48'hFEDCBA_987654};
    exp_beats = in_beats;
    run_frame(2'd0, 8'h00, 8'd0, 1, 0, 1'b1, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
